// File: rtl/cpc_bus_initiator.sv
// cpc_bus_initiator: Z80-style CPC expansion-bus master.
// Turns single-beat host commands (MEMRD, MEMWR, IOWR, BANKSEL) into legal
// T1/T2/TW/T3 bus cycles and keeps a shadow copy of the last bank configuration.
// Ports:
//   CLK, RESET_B                 clock, async active-low reset
//   req_valid/req_ready          host command handshake (ready only when idle)
//   req_cmd/req_addr/req_wdata   command, bus address, write data
//   rsp_valid/rsp_rdata          completion pulse, last MEMRD data
//   bank_cfg                     shadow of last BANKSEL configuration
//   A, D_out, D_oe, D_in         address and data bus
//   MREQ_B, IOREQ_B, RD_B, WR_B  active-low bus strobes
//   M1_B, RFSH_B                 tied inactive
//   READY                        bus wait request (0 extends the cycle)
module cpc_bus_initiator #(
  parameter logic [7:0]  BANK_PORT_HI = 8'h7F,
  parameter int unsigned MEM_WAITS    = 0,
  parameter int unsigned IO_WAITS     = 1
) (
  input  logic        CLK,
  input  logic        RESET_B,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_cmd,
  input  logic [15:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic [5:0]  bank_cfg,
  output logic [15:0] A,
  output logic [7:0]  D_out,
  output logic        D_oe,
  input  logic [7:0]  D_in,
  output logic        MREQ_B,
  output logic        IOREQ_B,
  output logic        RD_B,
  output logic        WR_B,
  output logic        M1_B,
  output logic        RFSH_B,
  input  logic        READY
);

  localparam int unsigned WCNT_W = 2;
  localparam logic [1:0]  CMD_MEMRD   = 2'b00;
  localparam logic [1:0]  CMD_BANKSEL = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_T1   = 3'd1,
    S_T2   = 3'd2,
    S_TW   = 3'd3,
    S_T3   = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic                is_mem_q, is_mem_d;
  logic                is_rd_q, is_rd_d;
  logic                is_bank_q, is_bank_d;
  logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
  logic [15:0]         a_q, a_d;
  logic [7:0]          d_out_q, d_out_d;
  logic                d_oe_q, d_oe_d;
  logic                mreq_b_q, mreq_b_d;
  logic                ioreq_b_q, ioreq_b_d;
  logic                rd_b_q, rd_b_d;
  logic                wr_b_q, wr_b_d;
  logic                req_ready_q, req_ready_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [7:0]          rsp_rdata_q, rsp_rdata_d;
  logic [5:0]          bank_cfg_q, bank_cfg_d;

  // State and registered bus/host outputs
  always_ff @(posedge CLK or negedge RESET_B) begin
    if (!RESET_B) begin
      state_q     <= S_IDLE;
      is_mem_q    <= 1'b0;
      is_rd_q     <= 1'b0;
      is_bank_q   <= 1'b0;
      wcnt_q      <= '0;
      a_q         <= 16'h0000;
      d_out_q     <= 8'h00;
      d_oe_q      <= 1'b0;
      mreq_b_q    <= 1'b1;
      ioreq_b_q   <= 1'b1;
      rd_b_q      <= 1'b1;
      wr_b_q      <= 1'b1;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 8'h00;
      bank_cfg_q  <= 6'h00;
    end else begin
      state_q     <= state_d;
      is_mem_q    <= is_mem_d;
      is_rd_q     <= is_rd_d;
      is_bank_q   <= is_bank_d;
      wcnt_q      <= wcnt_d;
      a_q         <= a_d;
      d_out_q     <= d_out_d;
      d_oe_q      <= d_oe_d;
      mreq_b_q    <= mreq_b_d;
      ioreq_b_q   <= ioreq_b_d;
      rd_b_q      <= rd_b_d;
      wr_b_q      <= wr_b_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      bank_cfg_q  <= bank_cfg_d;
    end
  end

  // Next state; outputs are computed for the state being entered so they appear with it
  always_comb begin
    state_d     = state_q;
    is_mem_d    = is_mem_q;
    is_rd_d     = is_rd_q;
    is_bank_d   = is_bank_q;
    wcnt_d      = wcnt_q;
    a_d         = a_q;
    d_out_d     = d_out_q;
    d_oe_d      = d_oe_q;
    mreq_b_d    = mreq_b_q;
    ioreq_b_d   = ioreq_b_q;
    rd_b_d      = rd_b_q;
    wr_b_d      = wr_b_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    bank_cfg_d  = bank_cfg_q;

    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          state_d     = S_T1;
          req_ready_d = 1'b0;
          is_mem_d    = ~req_cmd[1];
          is_rd_d     = (req_cmd == CMD_MEMRD);
          is_bank_d   = (req_cmd == CMD_BANKSEL);
          d_oe_d      = (req_cmd != CMD_MEMRD);
          // BANKSEL is an I/O write to the fixed bank port with the 11xxxxxx marker
          if (req_cmd == CMD_BANKSEL) begin
            a_d     = {BANK_PORT_HI, 8'hFF};
            d_out_d = {2'b11, req_wdata[5:0]};
          end else begin
            a_d = req_addr;
            if (req_cmd != CMD_MEMRD) begin
              d_out_d = req_wdata;
            end
          end
        end
      end
      S_T1: begin
        state_d   = S_T2;
        mreq_b_d  = ~is_mem_q;
        ioreq_b_d = is_mem_q;
        rd_b_d    = ~is_rd_q;
        wr_b_d    = is_rd_q;
        wcnt_d    = is_mem_q ? WCNT_W'(MEM_WAITS) : WCNT_W'(IO_WAITS);
      end
      S_T2, S_TW: begin
        // Forced waits run down first; READY low keeps extending afterwards
        if ((wcnt_q != '0) || !READY) begin
          state_d = S_TW;
          if (wcnt_q != '0) begin
            wcnt_d = wcnt_q - WCNT_W'(1);
          end
        end else begin
          state_d     = S_T3;
          mreq_b_d    = 1'b1;
          ioreq_b_d   = 1'b1;
          rd_b_d      = 1'b1;
          wr_b_d      = 1'b1;
          rsp_valid_d = 1'b1;
          if (is_rd_q) begin
            rsp_rdata_d = D_in;
          end
          if (is_bank_q) begin
            bank_cfg_d = d_out_q[5:0];
          end
        end
      end
      S_T3: begin
        state_d     = S_IDLE;
        d_oe_d      = 1'b0;
        req_ready_d = 1'b1;
      end
      default: begin
        state_d     = S_IDLE;
        req_ready_d = 1'b1;
      end
    endcase
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign bank_cfg  = bank_cfg_q;
  assign A         = a_q;
  assign D_out     = d_out_q;
  assign D_oe      = d_oe_q;
  assign MREQ_B    = mreq_b_q;
  assign IOREQ_B   = ioreq_b_q;
  assign RD_B      = rd_b_q;
  assign WR_B      = wr_b_q;
  assign M1_B      = 1'b1;
  assign RFSH_B    = 1'b1;

endmodule

// File: tb/tb_cpc_bus_initiator.sv
// Directed bench for cpc_bus_initiator: default-parameter instance plus a
// MEM_WAITS=2 / IO_WAITS=3 instance sharing the command fields.
module tb_cpc_bus_initiator;

  logic        CLK = 1'b0;
  logic        RESET_B;
  logic        req_valid, req_valid2;
  logic [1:0]  req_cmd;
  logic [15:0] req_addr;
  logic [7:0]  req_wdata;
  logic        READY = 1'b1;
  logic [7:0]  D_in;

  logic        req_ready, rsp_valid, D_oe, MREQ_B, IOREQ_B, RD_B, WR_B, M1_B, RFSH_B;
  logic [7:0]  rsp_rdata, D_out;
  logic [5:0]  bank_cfg;
  logic [15:0] A;

  logic        req_ready2, rsp_valid2, D_oe2, MREQ_B2, IOREQ_B2, RD_B2, WR_B2, M1_B2, RFSH_B2;
  logic [7:0]  rsp_rdata2, D_out2;
  logic [5:0]  bank_cfg2;
  logic [15:0] A2;

  int n_pass  = 0;
  int n_total = 0;
  int hold_cnt = 0;

  logic [7:0] mem [256];

  always #5 CLK = ~CLK;

  cpc_bus_initiator dut (
    .CLK(CLK), .RESET_B(RESET_B),
    .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .bank_cfg(bank_cfg),
    .A(A), .D_out(D_out), .D_oe(D_oe), .D_in(D_in),
    .MREQ_B(MREQ_B), .IOREQ_B(IOREQ_B), .RD_B(RD_B), .WR_B(WR_B),
    .M1_B(M1_B), .RFSH_B(RFSH_B), .READY(READY)
  );

  cpc_bus_initiator #(.MEM_WAITS(2), .IO_WAITS(3)) dut2 (
    .CLK(CLK), .RESET_B(RESET_B),
    .req_valid(req_valid2), .req_ready(req_ready2), .req_cmd(req_cmd),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid2), .rsp_rdata(rsp_rdata2), .bank_cfg(bank_cfg2),
    .A(A2), .D_out(D_out2), .D_oe(D_oe2), .D_in(D_in),
    .MREQ_B(MREQ_B2), .IOREQ_B(IOREQ_B2), .RD_B(RD_B2), .WR_B(WR_B2),
    .M1_B(M1_B2), .RFSH_B(RFSH_B2), .READY(READY)
  );

  // Simple RAM on the bus of the default instance
  always @(posedge CLK) begin
    if (!MREQ_B && !WR_B) mem[A[7:0]] <= D_out;
  end
  assign D_in = mem[A[7:0]];

  // Wait-request device: pulls READY low for hold_cnt strobe-active cycles
  always @(negedge CLK) begin
    if (hold_cnt > 0 && (!MREQ_B || !IOREQ_B)) begin
      READY = 1'b0;
      hold_cnt--;
    end else begin
      READY = 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
  endtask

  // Continuous bus protocol watch on the default instance
  logic [15:0] pa = 16'h0000;
  logic [3:0]  pstb = 4'hF;
  always @(negedge CLK) begin
    if (RESET_B === 1'b1) begin
      if (!MREQ_B || !IOREQ_B) chk("mreq_ioreq_excl", 32'(MREQ_B | IOREQ_B), 32'd1);
      if (!RD_B || !WR_B)      chk("rd_wr_excl", 32'(RD_B | WR_B), 32'd1);
      if (A !== pa)            chk("strobes_steady_on_a_change", 32'(pstb), 32'({MREQ_B, IOREQ_B, RD_B, WR_B}));
      if (pstb != 4'hF && {MREQ_B, IOREQ_B, RD_B, WR_B} != 4'hF) chk("a_stable_while_strobed", 32'(A), 32'(pa));
    end
    pa   = A;
    pstb = {MREQ_B, IOREQ_B, RD_B, WR_B};
  end

  typedef struct {
    int          wt;
    int          cyc;
    int          lm;
    int          li;
    int          lr;
    int          lw;
    logic [15:0] a1;
    logic [7:0]  d1;
    logic        oe1;
  } res_t;

  // Issue one command at a negedge; returns at the negedge of its rsp_valid cycle
  task automatic do_cmd(input bit sel, input logic [1:0] c, input logic [15:0] ad,
                        input logic [7:0] wd, output res_t r);
    req_cmd = c; req_addr = ad; req_wdata = wd;
    if (sel) req_valid2 = 1'b1; else req_valid = 1'b1;
    r.wt = 0;
    while (!(sel ? req_ready2 : req_ready) && r.wt < 20) begin
      @(negedge CLK);
      r.wt++;
    end
    @(negedge CLK);
    req_valid = 1'b0; req_valid2 = 1'b0;
    r.cyc = 1; r.lm = 0; r.li = 0; r.lr = 0; r.lw = 0;
    r.a1  = sel ? A2 : A;
    r.d1  = sel ? D_out2 : D_out;
    r.oe1 = sel ? D_oe2 : D_oe;
    while (!(sel ? rsp_valid2 : rsp_valid) && r.cyc < 60) begin
      @(negedge CLK);
      r.cyc++;
      if (!(sel ? MREQ_B2 : MREQ_B))   r.lm++;
      if (!(sel ? IOREQ_B2 : IOREQ_B)) r.li++;
      if (!(sel ? RD_B2 : RD_B))       r.lr++;
      if (!(sel ? WR_B2 : WR_B))       r.lw++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    res_t r;
    RESET_B = 1'b0; req_valid = 1'b0; req_valid2 = 1'b0;
    req_cmd = 2'b00; req_addr = 16'h0000; req_wdata = 8'h00;
    repeat (2) @(negedge CLK);
    RESET_B = 1'b1;
    @(negedge CLK);

    // Reset state
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_strobes", 32'({MREQ_B, IOREQ_B, RD_B, WR_B, M1_B, RFSH_B}), 32'h3F);
    chk("rst_d_oe", 32'(D_oe), 32'd0);
    chk("rst_a", 32'(A), 32'h0000);
    chk("rst_d_out", 32'(D_out), 32'h00);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_rdata", 32'(rsp_rdata), 32'h00);
    chk("rst_bank_cfg", 32'(bank_cfg), 32'h00);

    // BANKSEL cfg 04
    do_cmd(1'b0, 2'b11, 16'h1234, 8'h04, r);
    chk("bank_a", 32'(r.a1), 32'h7FFF);
    chk("bank_dout", 32'(r.d1), 32'hC4);
    chk("bank_oe", 32'(r.oe1), 32'd1);
    chk("bank_cycles", 32'(r.cyc), 32'd4);
    chk("bank_ioreq_low", 32'(r.li), 32'd2);
    chk("bank_wr_low", 32'(r.lw), 32'd2);
    chk("bank_mreq_low", 32'(r.lm), 32'd0);
    chk("bank_cfg", 32'(bank_cfg), 32'h04);
    chk("bank_rsp", 32'(rsp_valid), 32'd1);

    // MEMWR 4000 <= A5
    do_cmd(1'b0, 2'b01, 16'h4000, 8'hA5, r);
    chk("mw_idle_gap", 32'(r.wt), 32'd1);
    chk("mw_cycles", 32'(r.cyc), 32'd3);
    chk("mw_mreq_low", 32'(r.lm), 32'd1);
    chk("mw_wr_low", 32'(r.lw), 32'd1);
    chk("mw_a", 32'(r.a1), 32'h4000);
    chk("mw_dout", 32'(r.d1), 32'hA5);
    chk("mw_oe_t3", 32'(D_oe), 32'd1);
    @(negedge CLK);
    chk("mw_oe_idle", 32'(D_oe), 32'd0);
    chk("mw_ready_idle", 32'(req_ready), 32'd1);
    chk("mw_rsp_pulse", 32'(rsp_valid), 32'd0);

    // MEMRD 4000 -> A5
    do_cmd(1'b0, 2'b00, 16'h4000, 8'h00, r);
    chk("mr_cycles", 32'(r.cyc), 32'd3);
    chk("mr_rd_low", 32'(r.lr), 32'd1);
    chk("mr_oe", 32'(r.oe1), 32'd0);
    chk("mr_rdata", 32'(rsp_rdata), 32'hA5);

    // Back-to-back MEMWR then MEMRD with READY held low 4 cycles from T2
    do_cmd(1'b0, 2'b01, 16'h4001, 8'h3C, r);
    chk("b2b_wr_gap", 32'(r.wt), 32'd1);
    hold_cnt = 4;
    do_cmd(1'b0, 2'b00, 16'h4001, 8'h00, r);
    chk("b2b_rd_gap", 32'(r.wt), 32'd1);
    chk("rdwait_cycles", 32'(r.cyc), 32'd7);
    chk("rdwait_rd_low", 32'(r.lr), 32'd5);
    chk("rdwait_mreq_low", 32'(r.lm), 32'd5);
    chk("rdwait_rdata", 32'(rsp_rdata), 32'h3C);

    // IOWR keeps rsp_rdata and bank_cfg
    do_cmd(1'b0, 2'b10, 16'h1234, 8'h77, r);
    chk("io_cycles", 32'(r.cyc), 32'd4);
    chk("io_ioreq_low", 32'(r.li), 32'd2);
    chk("io_a", 32'(r.a1), 32'h1234);
    chk("io_dout", 32'(r.d1), 32'h77);
    chk("io_rdata_held", 32'(rsp_rdata), 32'h3C);
    chk("io_bank_held", 32'(bank_cfg), 32'h04);

    // Reset during TW of an IOWR
    @(negedge CLK);
    req_cmd = 2'b10; req_addr = 16'h00AB; req_wdata = 8'h11; req_valid = 1'b1;
    @(negedge CLK);
    req_valid = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    chk("tw_ioreq_low", 32'(IOREQ_B), 32'd0);
    RESET_B = 1'b0;
    #1;
    chk("abort_strobes", 32'({MREQ_B, IOREQ_B, RD_B, WR_B}), 32'hF);
    chk("abort_oe", 32'(D_oe), 32'd0);
    chk("abort_rsp", 32'(rsp_valid), 32'd0);
    chk("abort_bank", 32'(bank_cfg), 32'h00);
    chk("abort_a", 32'(A), 32'h0000);
    repeat (2) begin
      @(negedge CLK);
      chk("abort_rsp_in_reset", 32'(rsp_valid), 32'd0);
    end
    RESET_B = 1'b1;
    repeat (3) begin
      @(negedge CLK);
      chk("abort_no_rsp", 32'(rsp_valid), 32'd0);
      chk("abort_ready", 32'(req_ready), 32'd1);
    end

    // Parameter sweep instance: MEM_WAITS=2, IO_WAITS=3
    do_cmd(1'b1, 2'b01, 16'h0100, 8'h11, r);
    chk("p_mw_cycles", 32'(r.cyc), 32'd5);
    chk("p_mw_mreq_low", 32'(r.lm), 32'd3);
    do_cmd(1'b1, 2'b10, 16'h0200, 8'h22, r);
    chk("p_io_cycles", 32'(r.cyc), 32'd6);
    chk("p_io_ioreq_low", 32'(r.li), 32'd4);
    do_cmd(1'b1, 2'b11, 16'h0000, 8'h2A, r);
    chk("p_bank_cycles", 32'(r.cyc), 32'd6);
    chk("p_bank_dout", 32'(r.d1), 32'hEA);
    chk("p_bank_cfg", 32'(bank_cfg2), 32'h2A);
    chk("p_bank_other_inst", 32'(bank_cfg), 32'h00);

    repeat (2) @(negedge CLK);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
